// File: rtl/spi_pkg.sv
// Shared types for the SPI master.
//   spi_state_t : transfer FSM states
//   spi_mode_t  : mode bits latched when a transfer is accepted
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        XFER  = 2'd2,
        TRAIL = 2'd3
    } spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
        logic lsb_first;
    } spi_mode_t;

endpackage

// File: rtl/spi_clkgen.sv
// Half-period timer for the SPI master.
// While en is low the counter is parked at reload. While en is high it counts
// down and emits tick for one cycle when it reaches zero, then reloads.
// So with reload = D-1, tick fires every D cycles after en rises.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   en         : count enable
//   reload     : value loaded while disabled and after each tick
//   tick       : one-cycle expiry pulse
module spi_clkgen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] reload,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign tick = en && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (!en || tick) begin
            cnt_d = reload;
        end else begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_mc.sv
// Multi-mode SPI master: one WIDTH-bit transfer at a time, CPOL/CPHA,
// MSB/LSB first, runtime divider, NUM_CS active-low selects with hold.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   tx_data, tx_start     : word to send and start request
//   tx_ready              : idle, start will be accepted
//   rx_data, rx_valid     : received word and its one-cycle update pulse
//   cpol, cpha, lsb_first : mode, latched at accept
//   div                   : SCLK half-period in clk cycles (0 acts as 1)
//   cs_sel, cs_hold       : select index and keep-selected flag, latched at accept
//   cs_release            : in IDLE, drop a held select on the next cycle
//   sclk, mosi, miso      : SPI lines
//   cs_n                  : active-low chip selects
//   state_dbg             : current FSM state
//
// Handshake: a start is taken on a clock edge where tx_start and tx_ready are
// both high; tx_start while tx_ready is low is ignored with no side effect.
// rx_valid is a single-cycle pulse, there is no back-pressure on it.
module spi_master_mc
    import spi_pkg::*;
#(
    parameter int  WIDTH  = 8,
    parameter int  NUM_CS = 1,
    parameter int  DIV_W  = 16,
    localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  tx_data,
    input  logic              tx_start,
    output logic              tx_ready,
    output logic [WIDTH-1:0]  rx_data,
    output logic              rx_valid,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [DIV_W-1:0]  div,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              cs_hold,
    input  logic              cs_release,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_CS-1:0] cs_n,
    output logic [1:0]        state_dbg
);

    localparam int            EW        = $clog2(2 * WIDTH) + 1;
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * WIDTH);

    function automatic logic first_bit(input logic [WIDTH-1:0] v, input logic lsb);
        return lsb ? v[0] : v[WIDTH-1];
    endfunction

    function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v, input logic lsb);
        return lsb ? (v >> 1) : (v << 1);
    endfunction

    // Received bits enter from the end opposite to the transmit side so the
    // finished word lines up bit-for-bit with the transmitted word.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v, input logic b,
                                                  input logic lsb);
        return lsb ? {b, v[WIDTH-1:1]} : {v[WIDTH-2:0], b};
    endfunction

    // Out-of-range indices match no bit, so nothing gets selected.
    function automatic logic [NUM_CS-1:0] sel_mask(input logic [CS_W-1:0] s);
        logic [NUM_CS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_CS; i++) begin
            if (s == CS_W'(i)) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [DIV_W-1:0] half_reload(input logic [DIV_W-1:0] d);
        return (d == '0) ? '0 : d - DIV_W'(1);
    endfunction

    spi_state_t        state_q, state_d;
    spi_mode_t         mode_q, mode_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [CS_W-1:0]   cs_sel_q, cs_sel_d;
    logic              cs_hold_q, cs_hold_d;
    logic              rel_q, rel_d;        // LEAD is spending its first cycle releasing a stale select
    logic [WIDTH-1:0]  tx_sh_q, tx_sh_d;
    logic [WIDTH-1:0]  rx_sh_q, rx_sh_d;
    logic [WIDTH-1:0]  rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic [NUM_CS-1:0] cs_n_q, cs_n_d;
    logic [EW-1:0]     edge_cnt_q, edge_cnt_d;

    logic              tick;
    logic              clk_en;
    logic [DIV_W-1:0]  clk_reload;
    logic              accept;
    logic              edge_evt;
    logic [EW-1:0]     edge_num;
    logic              smp;
    logic              drv;
    logic [NUM_CS-1:0] new_mask;

    assign accept   = (state_q == IDLE) && tx_start;
    assign new_mask = sel_mask(cs_sel);

    // The LEAD expiry is itself edge 1, so the setup wait and the first
    // half-period share one timer run.
    assign edge_evt = tick && ((state_q == LEAD) || (state_q == XFER));
    assign edge_num = (state_q == LEAD) ? EW'(1) : edge_cnt_q + EW'(1);
    assign smp      = mode_q.cpha ? ~edge_num[0] : edge_num[0];
    assign drv      = mode_q.cpha ? edge_num[0] : (~edge_num[0] && (edge_num != LAST_EDGE));

    // Timer is held during the release cycle so the new select still gets a
    // full half-period of setup before edge 1.
    assign clk_en     = ((state_q == LEAD) && !rel_q) || (state_q == XFER) || (state_q == TRAIL);
    assign clk_reload = (state_q == IDLE) ? half_reload(div) : half_reload(div_q);

    spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (clk_en),
        .reload (clk_reload),
        .tick   (tick)
    );

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tx_start) state_d = LEAD;
            LEAD:    if (tick) state_d = XFER;
            XFER:    if (tick && (edge_num == LAST_EDGE)) state_d = TRAIL;
            TRAIL:   if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs and datapath
    always_comb begin
        mode_d     = mode_q;
        div_d      = div_q;
        cs_sel_d   = cs_sel_q;
        cs_hold_d  = cs_hold_q;
        rel_d      = rel_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        edge_cnt_d = edge_cnt_q;

        case (state_q)
            IDLE: begin
                sclk_d = mode_q.cpol;
                if (accept) begin
                    mode_d.cpol      = cpol;
                    mode_d.cpha      = cpha;
                    mode_d.lsb_first = lsb_first;
                    div_d            = div;
                    cs_sel_d         = cs_sel;
                    cs_hold_d        = cs_hold;
                    sclk_d           = cpol;
                    edge_cnt_d       = '0;
                    rx_sh_d          = '0;
                    if (!cpha) begin
                        mosi_d  = first_bit(tx_data, lsb_first);
                        tx_sh_d = shift_out(tx_data, lsb_first);
                    end else begin
                        tx_sh_d = tx_data;
                    end
                    // A different select still held from an earlier transfer
                    // is dropped for one cycle before the new one goes low.
                    if ((cs_n_q != '1) && (cs_n_q != ~new_mask)) begin
                        cs_n_d = '1;
                        rel_d  = 1'b1;
                    end else begin
                        cs_n_d = ~new_mask;
                        rel_d  = 1'b0;
                    end
                end else if (cs_release) begin
                    cs_n_d = '1;
                end
            end
            LEAD: begin
                if (rel_q) begin
                    cs_n_d = ~sel_mask(cs_sel_q);
                    rel_d  = 1'b0;
                end
            end
            TRAIL: begin
                if (tick) begin
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_sh_q;
                    if (!cs_hold_q) cs_n_d = '1;
                end
            end
            default: ;
        endcase

        if (edge_evt) begin
            sclk_d     = ~sclk_q;
            edge_cnt_d = edge_num;
            if (smp) rx_sh_d = shift_in(rx_sh_q, miso, mode_q.lsb_first);
            if (drv) begin
                mosi_d  = first_bit(tx_sh_q, mode_q.lsb_first);
                tx_sh_d = shift_out(tx_sh_q, mode_q.lsb_first);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= '0;
            div_q      <= '0;
            cs_sel_q   <= '0;
            cs_hold_q  <= 1'b0;
            rel_q      <= 1'b0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= '1;
            edge_cnt_q <= '0;
        end else begin
            mode_q     <= mode_d;
            div_q      <= div_d;
            cs_sel_q   <= cs_sel_d;
            cs_hold_q  <= cs_hold_d;
            rel_q      <= rel_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            edge_cnt_q <= edge_cnt_d;
        end
    end

    assign tx_ready  = (state_q == IDLE);
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign sclk      = sclk_q;
    assign mosi      = mosi_q;
    assign cs_n      = cs_n_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_spi_master_mc.sv
// Directed bench for spi_master_mc (WIDTH=8, NUM_CS=4).
// miso source: 0 = loopback from mosi, 1 = constant, 2 = behavioural slave on cs 0.
module tb_spi_master_mc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       cpol, cpha, lsb_first;
    logic [15:0] div;
    logic [1:0] cs_sel;
    logic       cs_hold;
    logic       cs_release;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic [3:0] cs_n;
    logic [1:0] state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] miso_sel = 2'd0;
    logic       miso_const = 1'b0;
    logic       miso_s = 1'b0;
    int         sclk_edges = 0;
    int         rxv_cnt = 0;

    // behavioural slave state
    logic       s_cpol = 1'b0;
    logic       s_cpha = 1'b0;
    logic [7:0] s_tx = 8'h00;
    logic [7:0] s_rx = 8'h00;

    assign miso = (miso_sel == 2'd0) ? mosi : (miso_sel == 2'd1) ? miso_const : miso_s;

    spi_master_mc #(.WIDTH(8), .NUM_CS(4), .DIV_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .cpol       (cpol),
        .cpha       (cpha),
        .lsb_first  (lsb_first),
        .div        (div),
        .cs_sel     (cs_sel),
        .cs_hold    (cs_hold),
        .cs_release (cs_release),
        .sclk       (sclk),
        .mosi       (mosi),
        .miso       (miso),
        .cs_n       (cs_n),
        .state_dbg  (state_dbg)
    );

    // clock
    always #5 clk = ~clk;

    always @(sclk) sclk_edges++;
    always @(negedge clk) if (rx_valid === 1'b1) rxv_cnt++;

    // slave: MSB first, always answers 8'h3C
    always @(negedge cs_n[0]) begin
        s_tx = 8'h3C;
        s_rx = 8'h00;
        if (!s_cpha) begin
            miso_s = s_tx[7];
            s_tx   = s_tx << 1;
        end
    end

    always @(sclk) begin
        if (cs_n[0] === 1'b0) begin
            if ((sclk != s_cpol) == !s_cpha) begin
                s_rx = {s_rx[6:0], mosi};
            end else begin
                miso_s = s_tx[7];
                s_tx   = s_tx << 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, tests did not finish");
        $fatal(1, "watchdog");
    end

    // Called at a negedge with tx_ready high; returns at the negedge after the
    // accepting edge (cycle T+1).
    task automatic start_xfer(input logic [7:0] d, input logic pol, input logic pha,
                              input logic lsb, input logic [15:0] dv, input logic [1:0] cs,
                              input logic hold);
        tx_data   = d;
        cpol      = pol;
        cpha      = pha;
        lsb_first = lsb;
        div       = dv;
        cs_sel    = cs;
        cs_hold   = hold;
        tx_start  = 1'b1;
        @(negedge clk);
        tx_start  = 1'b0;
    endtask

    // Steps negedges until rx_valid; lat is the T+n index, -1 on timeout.
    task automatic wait_done(input int n0, input int budget, output int lat);
        lat = n0;
        while (rx_valid !== 1'b1 && lat < budget) begin
            @(negedge clk);
            lat++;
        end
        if (rx_valid !== 1'b1) lat = -1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tx_data = '0; tx_start = 0; cpol = 0; cpha = 0; lsb_first = 0;
        div = '0; cs_sel = '0; cs_hold = 0; cs_release = 0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL rst_sclk: got %b expected 0", sclk); end
        n_checks++; if (mosi !== 1'b0) begin n_fail++; $display("FAIL rst_mosi: got %b expected 0", mosi); end
        n_checks++; if (cs_n !== 4'hF) begin n_fail++; $display("FAIL rst_cs_n: got %b expected 1111", cs_n); end
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_tx_ready: got %b expected 1", tx_ready); end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rx_valid: got %b expected 0", rx_valid); end
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rst_rx_data: got %h expected 00", rx_data); end
        n_checks++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d expected 0", state_dbg); end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (tx_ready !== 1'b1 || cs_n !== 4'hF) begin n_fail++; $display("FAIL post_rst_idle: got ready=%b cs_n=%b expected 1 1111", tx_ready, cs_n); end
    endtask

    task automatic test_mode0;
        int lat;
        miso_sel = 2'd0;
        sclk_edges = 0;
        start_xfer(8'hA5, 0, 0, 0, 16'd2, 2'd0, 0);
        n_checks++; if (cs_n !== 4'b1110) begin n_fail++; $display("FAIL m0_cs_fall: got %b expected 1110", cs_n); end
        n_checks++; if (mosi !== 1'b1) begin n_fail++; $display("FAIL m0_first_bit: got %b expected 1", mosi); end
        @(negedge clk);
        n_checks++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL m0_sclk_before_edge1: got %b expected 0", sclk); end
        @(negedge clk);
        n_checks++; if (sclk !== 1'b1) begin n_fail++; $display("FAIL m0_edge1_time: got %b expected 1", sclk); end
        wait_done(3, 200, lat);
        n_checks++; if (lat != 35) begin n_fail++; $display("FAIL m0_latency: got %0d expected 35", lat); end
        n_checks++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL m0_rx_data: got %h expected a5", rx_data); end
        n_checks++; if (sclk_edges != 16) begin n_fail++; $display("FAIL m0_edge_count: got %0d expected 16", sclk_edges); end
        n_checks++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL m0_sclk_idle: got %b expected 0", sclk); end
        n_checks++; if (tx_ready !== 1'b1 || cs_n !== 4'hF) begin n_fail++; $display("FAIL m0_end_state: got ready=%b cs_n=%b expected 1 1111", tx_ready, cs_n); end
        @(negedge clk);
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL m0_rx_valid_pulse: got %b expected 0", rx_valid); end
    endtask

    task automatic test_mode1;
        int lat;
        miso_sel = 2'd2; s_cpol = 1'b0; s_cpha = 1'b1;
        start_xfer(8'hC3, 0, 1, 0, 16'd3, 2'd0, 0);
        wait_done(1, 200, lat);
        n_checks++; if (lat != 52) begin n_fail++; $display("FAIL m1_latency: got %0d expected 52", lat); end
        n_checks++; if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL m1_rx_data: got %h expected 3c", rx_data); end
        n_checks++; if (s_rx !== 8'hC3) begin n_fail++; $display("FAIL m1_slave_rx: got %h expected c3", s_rx); end
        @(negedge clk);
    endtask

    task automatic test_mode3;
        int n;
        logic [7:0] got;
        miso_sel = 2'd1; miso_const = 1'b1;
        start_xfer(8'h01, 1, 1, 1, 16'd2, 2'd0, 0);
        n_checks++; if (sclk !== 1'b1) begin n_fail++; $display("FAIL m3_idle_high_at_accept: got %b expected 1", sclk); end
        n = 1;
        got = 8'h00;
        // mosi is stable at each even edge; bit k/2-1 is seen at T+1+2k
        while (rx_valid !== 1'b1 && n < 200) begin
            if (n >= 5 && ((n - 1) % 4) == 0) got[(n - 1) / 4 - 1] = mosi;
            @(negedge clk);
            n++;
        end
        n_checks++; if (n != 35) begin n_fail++; $display("FAIL m3_latency: got %0d expected 35", n); end
        n_checks++; if (got !== 8'h01) begin n_fail++; $display("FAIL m3_mosi_bits: got %b expected 00000001", got); end
        n_checks++; if (rx_data !== 8'hFF) begin n_fail++; $display("FAIL m3_rx_data: got %h expected ff", rx_data); end
        n_checks++; if (sclk !== 1'b1) begin n_fail++; $display("FAIL m3_sclk_idle: got %b expected 1", sclk); end
        @(negedge clk);
    endtask

    task automatic test_mode2;
        int lat;
        miso_sel = 2'd2; s_cpol = 1'b1; s_cpha = 1'b0;
        start_xfer(8'hC3, 1, 0, 0, 16'd1, 2'd0, 0);
        wait_done(1, 200, lat);
        n_checks++; if (lat != 18) begin n_fail++; $display("FAIL m2_latency: got %0d expected 18", lat); end
        n_checks++; if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL m2_rx_data: got %h expected 3c", rx_data); end
        n_checks++; if (s_rx !== 8'hC3) begin n_fail++; $display("FAIL m2_slave_rx: got %h expected c3", s_rx); end
        n_checks++; if (sclk !== 1'b1) begin n_fail++; $display("FAIL m2_sclk_idle: got %b expected 1", sclk); end
        @(negedge clk);
    endtask

    task automatic test_cs_hold;
        int lat;
        miso_sel = 2'd0;
        start_xfer(8'h5A, 0, 0, 0, 16'd1, 2'd2, 1);
        n_checks++; if (cs_n !== 4'b1011) begin n_fail++; $display("FAIL hold_cs2_sel: got %b expected 1011", cs_n); end
        wait_done(1, 200, lat);
        n_checks++; if (lat != 18) begin n_fail++; $display("FAIL hold_latency: got %0d expected 18", lat); end
        n_checks++; if (rx_data !== 8'h5A) begin n_fail++; $display("FAIL hold_rx_data: got %h expected 5a", rx_data); end
        n_checks++; if (cs_n !== 4'b1011) begin n_fail++; $display("FAIL hold_at_done: got %b expected 1011", cs_n); end
        @(negedge clk);
        n_checks++; if (cs_n !== 4'b1011) begin n_fail++; $display("FAIL hold_kept: got %b expected 1011", cs_n); end
        start_xfer(8'h0F, 0, 0, 0, 16'd1, 2'd1, 1);
        n_checks++; if (cs_n !== 4'b1111) begin n_fail++; $display("FAIL hold_release_first: got %b expected 1111", cs_n); end
        @(negedge clk);
        n_checks++; if (cs_n !== 4'b1101) begin n_fail++; $display("FAIL hold_cs1_sel: got %b expected 1101", cs_n); end
        wait_done(2, 200, lat);
        n_checks++; if (lat < 0 || rx_data !== 8'h0F) begin n_fail++; $display("FAIL hold_cs1_rx: got %h expected 0f", rx_data); end
        @(negedge clk);
        n_checks++; if (cs_n !== 4'b1101) begin n_fail++; $display("FAIL hold_cs1_kept: got %b expected 1101", cs_n); end
        cs_release = 1'b1;
        @(negedge clk);
        cs_release = 1'b0;
        n_checks++; if (cs_n !== 4'b1111) begin n_fail++; $display("FAIL cs_release: got %b expected 1111", cs_n); end
        cs_hold = 1'b0;
    endtask

    task automatic test_div0_ignore;
        int lat;
        miso_sel = 2'd0;
        rxv_cnt = 0;
        start_xfer(8'h96, 0, 0, 0, 16'd0, 2'd0, 0);
        @(negedge clk);
        tx_data = 8'hFF;
        tx_start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tx_start = 1'b0;
        wait_done(4, 200, lat);
        n_checks++; if (lat != 18) begin n_fail++; $display("FAIL div0_latency: got %0d expected 18", lat); end
        n_checks++; if (rx_data !== 8'h96) begin n_fail++; $display("FAIL div0_rx_data: got %h expected 96", rx_data); end
        repeat (25) @(negedge clk);
        n_checks++; if (rxv_cnt != 1) begin n_fail++; $display("FAIL busy_start_ignored: got %0d rx_valid pulses expected 1", rxv_cnt); end
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL busy_start_idle: got %b expected 1", tx_ready); end
    endtask

    task automatic test_back_to_back;
        int lat;
        miso_sel = 2'd0;
        start_xfer(8'h3C, 0, 0, 0, 16'd1, 2'd0, 0);
        wait_done(1, 200, lat);
        n_checks++; if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL b2b_first_rx: got %h expected 3c", rx_data); end
        start_xfer(8'hC5, 0, 0, 0, 16'd1, 2'd0, 0);
        n_checks++; if (tx_ready !== 1'b0 || cs_n !== 4'b1110) begin n_fail++; $display("FAIL b2b_accept: got ready=%b cs_n=%b expected 0 1110", tx_ready, cs_n); end
        wait_done(1, 200, lat);
        n_checks++; if (lat != 18) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 18", lat); end
        n_checks++; if (rx_data !== 8'hC5) begin n_fail++; $display("FAIL b2b_second_rx: got %h expected c5", rx_data); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int lat;
        miso_sel = 2'd0;
        rxv_cnt = 0;
        start_xfer(8'hA5, 0, 0, 0, 16'd2, 2'd0, 0);
        repeat (10) @(negedge clk);
        n_checks++; if (sclk !== 1'b1) begin n_fail++; $display("FAIL rmid_edge5: got sclk %b expected 1", sclk); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (sclk !== 1'b0 || mosi !== 1'b0) begin n_fail++; $display("FAIL rmid_lines: got sclk=%b mosi=%b expected 0 0", sclk, mosi); end
        n_checks++; if (cs_n !== 4'hF) begin n_fail++; $display("FAIL rmid_cs_n: got %b expected 1111", cs_n); end
        n_checks++; if (tx_ready !== 1'b1 || rx_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_flags: got ready=%b valid=%b expected 1 0", tx_ready, rx_valid); end
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rmid_rx_data: got %h expected 00", rx_data); end
        n_checks++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL rmid_state: got %0d expected 0", state_dbg); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (rxv_cnt != 0) begin n_fail++; $display("FAIL rmid_no_rx_valid: got %0d pulses expected 0", rxv_cnt); end
        start_xfer(8'hB7, 0, 0, 0, 16'd2, 2'd0, 0);
        wait_done(1, 200, lat);
        n_checks++; if (lat != 35) begin n_fail++; $display("FAIL rmid_restart_latency: got %0d expected 35", lat); end
        n_checks++; if (rx_data !== 8'hB7) begin n_fail++; $display("FAIL rmid_restart_rx: got %h expected b7", rx_data); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode1();
        test_mode3();
        test_mode2();
        test_cs_hold();
        test_div0_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
